// File: rtl/sram_sp_pkg.sv
// Shared definitions for the single-port SRAM initiator and its SRAM model:
// FSM state encoding and default bus widths.
package sram_sp_pkg;

    localparam int STATE_W    = 3;
    localparam int DEF_DWIDTH = 8;
    localparam int DEF_AWIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        TURN    = 3'd4
    } state_t;

endpackage

// File: rtl/sram_sp_initiator.sv
// Valid/ready host port to single-port synchronous SRAM pins, owning bus direction.
// Optional macro SRAM_SP_INITIATOR_TURNAROUND_EN inserts an idle TURN cycle on read-to-write.
module sram_sp_initiator
    import sram_sp_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [AWIDTH-1:0] mem_addr,
    inout  logic [DWIDTH-1:0] mem_data
);

    state_t            state;
    state_t            next_state;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              we_q;
    logic              accept;

    assign accept = req_valid && req_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, WRITE, RD_DATA: begin
                if (accept) begin
                    if (!req_we) begin
                        next_state = RD_ADDR;
                    end else begin
`ifdef SRAM_SP_INITIATOR_TURNAROUND_EN
                        next_state = (state == RD_DATA) ? TURN : WRITE;
`else
                        next_state = WRITE;
`endif
                    end
                end
            end
            RD_ADDR: next_state = RD_DATA;
`ifdef SRAM_SP_INITIATOR_TURNAROUND_EN
            TURN:    next_state = WRITE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
            end
            // The SRAM drives its registered word during RD_DATA; capture it at that cycle's end.
            rsp_valid <= (state == RD_DATA);
            if (state == RD_DATA) begin
                rsp_rdata <= mem_data;
            end
        end
    end

    assign req_ready = (state == IDLE) || (state == WRITE) || (state == RD_DATA);
    assign busy      = (state != IDLE);
    assign mem_cs    = (state == WRITE) || (state == RD_ADDR) || (state == RD_DATA);
    assign mem_we    = (state == WRITE) && we_q;
    assign mem_oe    = (state == RD_ADDR) || (state == RD_DATA);
    assign mem_addr  = addr_q;

    // Only WRITE drives the bus; the SRAM can only drive while oe is high, which excludes WRITE.
    assign mem_data = (state == WRITE) ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_sram_sp_initiator.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// against a cycle-schedule reference model plus a behavioural synchronous SRAM.
module tb_sram_sp_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy, mem_cs, mem_we, mem_oe;
    logic [7:0] mem_addr;
    wire  [7:0] mem_data;

    always #5 clk = ~clk;

    sram_sp_initiator #(.DWIDTH(8), .AWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Behavioural SRAM: write on edge, registered read driven the cycle after sampling.
    logic [7:0] sram_mem [256];
    logic [7:0] sram_dout;
    logic       sram_rd_q;
    logic       sram_drv;
    assign sram_drv = mem_oe && sram_rd_q;
    assign mem_data = sram_drv ? sram_dout : 8'hzz;

    always @(posedge clk) begin
        if (mem_cs && mem_we) sram_mem[mem_addr] <= mem_data;
        if (mem_cs && !mem_we) sram_dout <= sram_mem[mem_addr];
        sram_rd_q <= mem_cs && !mem_we && mem_oe;
    end

    // Reference model: expected per-cycle activity keyed by cycle number.
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ready_from = 0;
    int         last_rd = -100;
    logic [7:0] ref_mem [256];
    logic [7:0] exp_hold = 8'h00;
    bit         exp_we [int];
    bit         exp_rd [int];
    bit         exp_turn [int];
    logic [7:0] exp_wa [int];
    logic [7:0] exp_wd [int];
    logic [7:0] exp_ra [int];
    logic [7:0] exp_rsp [int];

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_we.delete(); exp_rd.delete(); exp_turn.delete();
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_rsp.delete();
        ready_from = 0;
        last_rd    = -100;
    endtask

    task automatic model_accept(input bit we, input logic [7:0] a, input logic [7:0] d, input int e);
        int w;
        w = e;
        if (!we) begin
            exp_rd[e] = 1'b1; exp_rd[e+1] = 1'b1;
            exp_ra[e] = a;    exp_ra[e+1] = a;
            exp_rsp[e+2] = ref_mem[a];
            ready_from = e + 1;
            last_rd = e;
        end else begin
`ifdef SRAM_SP_INITIATOR_TURNAROUND_EN
            if (last_rd == e - 2) begin
                exp_turn[e] = 1'b1;
                w = e + 1;
                ready_from = e + 1;
            end
`endif
            exp_we[w] = 1'b1;
            exp_wa[w] = a;
            exp_wd[w] = d;
            ref_mem[a] = d;
        end
    endtask

    task automatic check_cycle();
        bit w, r, t, v;
        w = exp_we.exists(cyc);
        r = exp_rd.exists(cyc);
        t = exp_turn.exists(cyc);
        v = exp_rsp.exists(cyc);
        check("req_ready", req_ready, cyc >= ready_from);
        check("busy", busy, w || r || t);
        check("mem_cs", mem_cs, w || r);
        check("mem_we", mem_we, w);
        check("mem_oe", mem_oe, r);
        check("bus_contention", sram_drv && mem_we, 1'b0);
        if (w) begin
            check("wr_addr", mem_addr, exp_wa[cyc]);
            check("wr_data", mem_data, exp_wd[cyc]);
        end
        if (r) check("rd_addr", mem_addr, exp_ra[cyc]);
        check("rsp_valid", rsp_valid, v);
        if (v) exp_hold = exp_rsp[cyc];
        check("rsp_rdata", rsp_rdata, exp_hold);
    endtask

    task automatic tick(input bit v, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output bit acc);
        @(negedge clk);
        check_cycle();
        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        acc = v && (cyc >= ready_from);
        if (acc) model_accept(we, a, d, cyc + 1);
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 8'h00, acc);
    endtask

    task automatic send(input bit we, input logic [7:0] a, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) tick(1'b1, we, a, d, acc);
        check("send_accept", acc, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, mem_cs, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_oe"}, mem_oe, 1'b0);
        check({tag, "_addr"}, mem_addr, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
        check({tag, "_ready"}, req_ready, 1'b1);
    endtask

    vec_t vecs [8];

    initial begin
        bit acc;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        sram_dout = 8'h00;
        sram_rd_q = 1'b0;
        vecs[0] = '{1'b1, 8'h05, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h05, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'h5A, 8'h00};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h5A};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        cyc = 1;
        clear_model();

        // Directed table: single transactions with the bus fully drained between them.
        foreach (vecs[i]) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            idle(4);
            if (!vecs[i].we) check("table_rdata", rsp_rdata, vecs[i].exp_rdata);
        end
        check("sram_mem5", sram_mem[5], 8'hA5);
        check("sram_memFF", sram_mem[255], 8'hFF);
        check("sram_mem00", sram_mem[0], 8'h5A);

        // Back-to-back writes with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 8'(8'h10 + i), 8'(i + 1), acc);
            check("b2b_accept", acc, 1'b1);
        end
        idle(2);
        for (int i = 0; i < 4; i++) check("b2b_mem", sram_mem[8'h10 + i], 8'(i + 1));

        // Read immediately followed by a write (direct or via TURN).
        tick(1'b1, 1'b0, 8'h10, 8'h00, acc);
        check("rw_read_accept", acc, 1'b1);
        send(1'b1, 8'h11, 8'hFF);
        idle(5);
        check("rw_rdata", rsp_rdata, 8'h01);
        check("rw_mem11", sram_mem[8'h11], 8'hFF);

        // Reset asserted while in RD_DATA drops the read.
        tick(1'b1, 1'b0, 8'h12, 8'h00, acc);
        check("rst_read_accept", acc, 1'b1);
        idle(1);
        @(negedge clk);
        check_cycle();
        check("rst_in_rd_data", mem_oe && !dut.req_ready, 1'b0);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        clear_model();
        exp_hold = 8'h00;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("midrst_no_pulse", rsp_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        idle(2);
        send(1'b0, 8'h12, 8'h00);
        idle(4);
        check("post_rst_rdata", rsp_rdata, 8'h03);

        // Random traffic against the schedule model.
        for (int i = 0; i < 400; i++) begin
            bit         v, we;
            logic [7:0] a, d;
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d  = 8'($urandom);
            tick(v, we, a, d, acc);
        end
        idle(6);
        for (int i = 0; i < 256; i++) check("mem_image", sram_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_sp_initiator.md
Name: sram_sp_initiator

Overview:
- Bus initiator that drives the single-port synchronous SRAM pin interface: cs, we, oe, addr and a bidirectional data bus.
- Host side is a valid/ready request channel plus a one-cycle read-response pulse.
- Sits between a host engine and the SRAM. It sequences the chip's registered read (data driven one cycle after the sampling edge) and its write-on-edge behaviour.
- Owns bus direction, so the initiator and the SRAM never drive the data bus at the same time.

Parameters:
- DWIDTH, 8, data bus width; must equal the SRAM's DWIDTH.
- AWIDTH, 8, address width; must equal the SRAM's AWIDTH.

Ports:
- clk  in  1  rising-edge clock shared with the SRAM
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  initiator accepts the request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AWIDTH  request address
- req_wdata  in  DWIDTH  write data
- rsp_valid  out  1  one-cycle pulse; rsp_rdata valid
- rsp_rdata  out  DWIDTH  read data
- busy  out  1  state != IDLE
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_oe  out  1  SRAM output enable
- mem_addr  out  AWIDTH  SRAM address
- mem_data  inout  DWIDTH  SRAM data bus, tristated when not writing

Behaviour:
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. On acceptance, addr/wdata/we are captured into registers addr_q/wdata_q/we_q.
- req_ready = 1 in IDLE, WRITE and RD_DATA, so back-to-back requests chain with no idle cycle. req_ready = 0 in RD_ADDR and TURN.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, TURN (TURN exists only with the optional feature).
- Accepted write -> WRITE. Accepted read -> RD_ADDR. No accept in IDLE/WRITE/RD_DATA -> IDLE.
- RD_ADDR -> RD_DATA unconditionally.
- Memory outputs are a Moore decode of the state register; mem_addr = addr_q.
  - IDLE / TURN: cs=0, we=0, oe=0, mem_data = z.
  - WRITE: cs=1, we=1, oe=0, mem_data driven with wdata_q. The SRAM captures the data on the edge that ends this cycle.
  - RD_ADDR: cs=1, we=0, oe=1, mem_data = z. The SRAM registers mem[addr] on the edge ending this cycle.
  - RD_DATA: cs=1, we=0, oe=1, mem_data = z (SRAM drives). The initiator samples mem_data into rsp_rdata on the edge ending this cycle.
- Read response: rsp_valid is registered and high for exactly one cycle, the cycle after RD_DATA.
  - rsp_rdata holds its value until the next read completes.
- Latency, counted from the acceptance edge E0:
  - Write: mem_we high during cycle E0..E1; memory updated at E1.
  - Read: rsp_valid high during cycle E2..E3, i.e. 2 cycles.
- Throughput: one write per cycle; one read per 2 cycles.
- Read after write to the same address returns the new data, because the write commits before RD_ADDR samples.
- mem_data is driven only when state == WRITE. The initiator never drives in RD_ADDR or RD_DATA.
- Reset (asynchronous, any state):
  - State -> IDLE.
  - req_ready = 1 once reset is released.
  - rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - mem_cs/we/oe = 0, mem_addr = 0, mem_data = z.
  - An in-flight transaction is dropped with no response.
- Host-side inputs are ignored when req_valid = 0, and also while req_ready = 0 (the host must hold the request).

Optional Feature:
- Macro: SRAM_SP_INITIATOR_TURNAROUND_EN.
- Defined:
  - A write accepted in RD_DATA goes to TURN (one cycle, all mem strobes low, bus z), then to WRITE.
  - req_ready = 0 in TURN.
  - Reads accepted in RD_DATA and all other paths are unchanged.
  - Write-after-read latency increases by 1 cycle.
- Undefined: the TURN state and its logic are absent; RD_DATA -> WRITE is direct.

Decomposition:
- Package sram_sp_pkg:
  - State encoding constants (IDLE=0, WRITE=1, RD_ADDR=2, RD_DATA=3, TURN=4) and the 3-bit state width.
  - Default DWIDTH/AWIDTH constants shared with the SRAM model.
- No sub-module is required. The tristate driver stays as a single continuous assign in the top.

Test Plan:
- Reset released, write addr 0x05 data 0xA5 accepted -> mem_cs=1 and mem_we=1 for exactly 1 cycle with mem_data=0xA5; SRAM mem[5]=0xA5.
- Read addr 0x05 after the previous write -> rsp_valid single pulse 2 cycles after acceptance, rsp_rdata=0xA5; mem_data never driven by the initiator during the read.
- Back-to-back writes 0x10..0x13 with data 0x01..0x04, req_valid held -> req_ready=1 every cycle, 4 consecutive WRITE cycles, SRAM contents match.
- Read 0x10 immediately followed by write 0x11=0xFF:
  - Without the macro: WRITE directly follows RD_DATA.
  - With the macro: one TURN cycle with cs=0 and bus z.
  - In both cases rsp_rdata=0x01, and the bus is never driven by both sides (no X).
- Assert rst_n=0 while in RD_DATA -> outputs immediately 0/z, no rsp_valid pulse; after release, a read of 0x12 returns 0x03.
- Write and read of addr 0xFF with data 0x00 and 0xFF (address/data boundaries) -> correct data returned, no aliasing with addr 0x00.
